// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared widths and scan FSM encoding for the ROM scan controller
package rom_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 4;
    localparam int SUM_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry {addr,data} FIFO; slot0 is always the head
module stream_fifo2 #(
    parameter int AW = 6,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          valid,
    output logic [1:0]    fill
);

    logic [AW+DW-1:0] slot0;
    logic [AW+DW-1:0] slot1;
    logic [AW+DW-1:0] push_word;
    logic             do_pop;
    logic             do_push;

    assign push_word = {push_addr, push_data};
    assign do_pop    = pop && (fill != 2'd0);
    assign do_push   = push && (do_pop || (fill != 2'd2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            fill  <= 2'd0;
        end else if (do_push && do_pop) begin
            if (fill == 2'd2) begin
                slot0 <= slot1;
                slot1 <= push_word;
            end else begin
                slot0 <= push_word;
            end
        end else if (do_pop) begin
            slot0 <= slot1;
            fill  <= fill - 2'd1;
        end else if (do_push) begin
            if (fill == 2'd0) begin
                slot0 <= push_word;
            end else begin
                slot1 <= push_word;
            end
            fill <= fill + 2'd1;
        end
    end

    assign valid     = (fill != 2'd0);
    assign head_addr = slot0[AW+DW-1:DW];
    assign head_data = slot0[DW-1:0];

endmodule

// File: rtl/rom_scan_ctrl.sv
// rtl/rom_scan_ctrl.sv - walks a wrapped address range of a registered-address ROM onto a stream
module rom_scan_ctrl #(
    parameter int ADDR_W = rom_pkg::ADDR_W,
    parameter int DATA_W = rom_pkg::DATA_W,
    parameter int SUM_W  = rom_pkg::SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  sum
);

    import rom_pkg::*;

    scan_state_t       state;
    scan_state_t       state_nxt;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   issued;
    logic              pending;
    logic [1:0]        fill;
    logic [2:0]        occ;
    logic              pop;
    logic              issue;
    logic              start_ok;

    // Occupancy counts the read in flight so the FIFO can never be overrun.
    assign pop        = out_valid && out_ready;
    assign occ        = 3'(fill) + 3'(pending) - 3'(pop);
    assign issue      = (state == ST_RUN) && (issued != len_r) && (occ < 3'd2);
    assign issue_addr = base_addr + issued[ADDR_W-1:0];
    assign rom_addr   = issue ? issue_addr : last_addr;
    assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_nxt = (length == '0) ? ST_DONE : ST_RUN;
                end else if (state == ST_DONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue && ((issued + (ADDR_W+1)'(1)) == len_r)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((fill == 2'd0) && !pending) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            last_addr <= '0;
            pend_addr <= '0;
            len_r     <= '0;
            issued    <= '0;
            pending   <= 1'b0;
            sum       <= '0;
        end else begin
            state   <= state_nxt;
            pending <= issue;
            if (issue) begin
                issued    <= issued + (ADDR_W+1)'(1);
                last_addr <= issue_addr;
                pend_addr <= issue_addr;
            end
            if (start_ok) begin
                base_addr <= start_addr;
                len_r     <= length;
                issued    <= '0;
                sum       <= '0;
            end else if (pop) begin
                sum <= sum + SUM_W'(out_data);
            end
        end
    end

    stream_fifo2 #(
        .AW(ADDR_W),
        .DW(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending),
        .push_addr (pend_addr),
        .push_data (rom_q),
        .pop       (pop),
        .head_addr (out_addr),
        .head_data (out_data),
        .valid     (out_valid),
        .fill      (fill)
    );

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// tb/tb_rom_scan_ctrl.sv - scoreboard bench for rom_scan_ctrl with a registered-address ROM model
module tb_rom_scan_ctrl;

    localparam int AW = 6;
    localparam int DW = 4;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SW-1:0] sum;
    logic [AW-1:0] rom_reg = '0;

    rom_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_reg <= rom_addr;
    assign rom_q = rom_reg[DW-1:0];

    typedef struct {
        int addr;
        int data;
    } word_t;

    word_t   exp_q[$];
    int      exp_sum_q[$];
    word_t   w;
    int      n_vec = 0;
    int      n_err = 0;
    int      xfer_cnt = 0;
    bit      ready_rand = 1'b0;
    bit      stalled = 1'b0;
    logic [AW-1:0] stall_addr;
    logic [DW-1:0] stall_data;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_payload_stable", {out_addr, out_data}, {stall_addr, stall_data});
            end
            stalled    = out_valid && !out_ready;
            stall_addr = out_addr;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word_addr", out_addr, 999);
                end else begin
                    w = exp_q.pop_front();
                    check("word_addr", out_addr, w.addr);
                    check("word_data", out_data, w.data);
                end
                xfer_cnt++;
            end
            if (done) begin
                if (exp_sum_q.size() == 0) check("extra_done_sum", sum, 99999);
                else check("sum", sum, exp_sum_q.pop_front());
            end
        end
    end

    task automatic expect_scan(input int sa, input int len);
        int s;
        int a;
        s = 0;
        for (int i = 0; i < len; i++) begin
            a = (sa + i) % 64;
            exp_q.push_back('{a, a % 16});
            s += a % 16;
        end
        exp_sum_q.push_back(s);
    endtask

    task automatic run_scan(input int sa, input int len, input bit inject);
        int first;
        int vcnt;
        int bcnt;
        int dcyc;
        first = -1;
        vcnt  = 0;
        bcnt  = 0;
        dcyc  = -1;
        expect_scan(sa, len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = sa[AW-1:0];
        length     = len[AW:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                vcnt++;
                if (first < 0) first = cyc;
            end
            if (busy) bcnt++;
            if (done) begin
                dcyc = cyc;
                break;
            end
            if (inject && cyc == 6) begin
                start      = 1'b1;
                start_addr = 6'(sa + 17);
                length     = 7'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", dcyc > 0, 1);
        if (len == 0) begin
            check("empty_done_cycle", dcyc, 1);
            check("empty_no_valid", vcnt, 0);
            check("empty_no_busy", bcnt, 0);
        end else begin
            check("first_word_latency", first, 3);
            check("busy_span", bcnt, dcyc - 1);
            if (!ready_rand) check("throughput", vcnt, len);
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("words_left", exp_q.size(), 0);
        check("sums_left", exp_sum_q.size(), 0);
    endtask

    task automatic reset_mid_scan();
        int base;
        int dcnt;
        int vcnt;
        bit hit;
        base = xfer_cnt;
        hit  = 1'b0;
        expect_scan(20, 10);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 6'd20;
        length     = 7'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (xfer_cnt - base >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("reset_point_reached", hit, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", out_valid, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_addr", out_addr, 0);
        check("abort_sum", sum, 0);
        exp_q.delete();
        exp_sum_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            dcnt += int'(done);
            vcnt += int'(out_valid);
        end
        check("abort_no_done", dcnt, 0);
        check("abort_no_valid", vcnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_sum", sum, 0);
        rst_n = 1'b1;

        ready_rand = 1'b0;
        run_scan(0, 4, 1'b0);
        run_scan(62, 4, 1'b0);
        ready_rand = 1'b1;
        run_scan(0, 16, 1'b0);
        ready_rand = 1'b0;
        run_scan(33, 0, 1'b0);
        ready_rand = 1'b1;
        run_scan(10, 12, 1'b1);
        ready_rand = 1'b0;
        reset_mid_scan();
        run_scan(5, 10, 1'b0);
        run_scan(63, 64, 1'b0);
        ready_rand = 1'b1;
        run_scan(63, 64, 1'b0);
        for (int k = 0; k < 10; k++) begin
            ready_rand = 1'($urandom_range(0, 1));
            run_scan(int'($urandom_range(0, 63)), int'($urandom_range(0, 64)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
